tsp_tour_eval: RTL and testbench

- Downstream consumer of the `tsp` search core. Receives each candidate tour as a stream of city indices, one per cycle.
- Looks up inter-city distances in an internal distance table and accumulates the closed-tour cost, including the return edge to the first city.
- Validates the tour as a permutation, reports its cost, and tracks the best (minimum) valid cost seen since reset.

---
 rtl/tsp_tour_eval_if.sv | 26 ++
 rtl/tsp_tour_eval.sv | 228 ++++++++++++++++++++++
 tb/tb_tsp_tour_eval.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsp_tour_eval_if.sv
// Tour stream and result bundle for tsp_tour_eval.
// master drives the city stream; slave is the evaluator.
interface tsp_tour_eval_if #(
    parameter int CITY_W = 3,
    parameter int COST_W = 12
);
    logic              city_valid;
    logic              city_ready;
    logic [CITY_W-1:0] city_idx;
    logic              city_last;
    logic              cost_valid;
    logic [COST_W-1:0] cost;
    logic              tour_err;
    logic [COST_W-1:0] best_cost;
    logic              best_upd;

    modport master (
        output city_valid, city_idx, city_last,
        input  city_ready, cost_valid, cost, tour_err, best_cost, best_upd
    );

    modport slave (
        input  city_valid, city_idx, city_last,
        output city_ready, cost_valid, cost, tour_err, best_cost, best_upd
    );
endinterface

// File: rtl/tsp_tour_eval.sv
// Closed-tour cost evaluator with permutation check and best-cost tracking.
// Optional best-tour capture and readback when TSP_BEST_TOUR_EN is defined.
module tsp_tour_eval #(
    parameter int N_CITY = 8,
    parameter int CITY_W = 3,
    parameter int DIST_W = 8,
    parameter int COST_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dist_we,
    input  logic [CITY_W-1:0] dist_wi,
    input  logic [CITY_W-1:0] dist_wj,
    input  logic [DIST_W-1:0] dist_wdata,
`ifdef TSP_BEST_TOUR_EN
    input  logic [CITY_W-1:0] best_rd_idx,
    output logic [CITY_W-1:0] best_rd_city,
`endif
    tsp_tour_eval_if.slave    tour
);

    localparam int IDX_W = (N_CITY > 1) ? $clog2(N_CITY) : 1;
    localparam int CNT_W = $clog2(N_CITY + 2);
    localparam int SUM_W = ((COST_W > DIST_W) ? COST_W : DIST_W) + 1;
    localparam logic [COST_W-1:0] COST_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_CITY);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(N_CITY + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CLOSE, DONE} state_t;

    function automatic logic in_range(input logic [CITY_W-1:0] c);
        return (int'(c) < N_CITY);
    endfunction

    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(COST_MAX)) ? COST_MAX : s[COST_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [CITY_W-1:0]   first_q, first_d;
    logic [CITY_W-1:0]   prev_q, prev_d;
    logic [COST_W-1:0]   acc_q, acc_d;
    logic [N_CITY-1:0]   visited_q, visited_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic [COST_W-1:0]   cost_q, cost_d;
    logic                cost_valid_q, cost_valid_d;
    logic                tour_err_q, tour_err_d;
    logic [COST_W-1:0]   best_cost_q, best_cost_d;
    logic                best_upd_q, best_upd_d;

    logic [DIST_W-1:0]   dist_q [N_CITY][N_CITY];
    logic [DIST_W-1:0]   step_dist;
    logic [DIST_W-1:0]   close_dist;
    logic                city_ready;
    logic                accept;
    logic                idx_ok;
    logic [N_CITY-1:0]   idx_oh;

    // Distance table: old value is seen on a same-cycle read, out-of-range writes dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CITY; i++) begin
                for (int unsigned j = 0; j < N_CITY; j++) begin
                    dist_q[i][j] <= '0;
                end
            end
        end else if (dist_we && in_range(dist_wi) && in_range(dist_wj)) begin
            dist_q[dist_wi[IDX_W-1:0]][dist_wj[IDX_W-1:0]] <= dist_wdata;
        end
    end

    always_comb begin
        step_dist = '0;
        if (in_range(prev_q) && in_range(tour.city_idx)) begin
            step_dist = dist_q[prev_q[IDX_W-1:0]][tour.city_idx[IDX_W-1:0]];
        end
    end

    always_comb begin
        close_dist = '0;
        if (in_range(prev_q) && in_range(first_q)) begin
            close_dist = dist_q[prev_q[IDX_W-1:0]][first_q[IDX_W-1:0]];
        end
    end

    assign city_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign accept     = tour.city_valid && city_ready;
    assign idx_ok     = in_range(tour.city_idx);
    assign idx_oh     = idx_ok ? (N_CITY'(1) << tour.city_idx[IDX_W-1:0]) : '0;

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        prev_d       = prev_q;
        acc_d        = acc_q;
        visited_d    = visited_q;
        count_d      = count_q;
        err_d        = err_q;
        cost_d       = cost_q;
        cost_valid_d = 1'b0;
        tour_err_d   = tour_err_q;
        best_cost_d  = best_cost_q;
        best_upd_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    first_d   = tour.city_idx;
                    prev_d    = tour.city_idx;
                    acc_d     = '0;
                    visited_d = idx_oh;
                    count_d   = CNT_W'(1);
                    err_d     = !idx_ok;
                    state_d   = tour.city_last ? CLOSE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d     = sat_add(acc_q, step_dist);
                    prev_d    = tour.city_idx;
                    // Count saturates past N_CITY so long tours can never alias a full one
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (!idx_ok || ((visited_q & idx_oh) != '0)) begin
                        err_d = 1'b1;
                    end
                    visited_d = visited_q | idx_oh;
                    if (tour.city_last) begin
                        state_d = CLOSE;
                    end
                end
            end
            CLOSE: begin
                acc_d = sat_add(acc_q, close_dist);
                if (count_q != CNT_FULL) begin
                    err_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                cost_d       = acc_q;
                tour_err_d   = err_q;
                cost_valid_d = 1'b1;
                if (!err_q && (acc_q < best_cost_q)) begin
                    best_cost_d = acc_q;
                    best_upd_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            first_q      <= '0;
            prev_q       <= '0;
            acc_q        <= '0;
            visited_q    <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            cost_q       <= '0;
            cost_valid_q <= 1'b0;
            tour_err_q   <= 1'b0;
            best_cost_q  <= '1;
            best_upd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            prev_q       <= prev_d;
            acc_q        <= acc_d;
            visited_q    <= visited_d;
            count_q      <= count_d;
            err_q        <= err_d;
            cost_q       <= cost_d;
            cost_valid_q <= cost_valid_d;
            tour_err_q   <= tour_err_d;
            best_cost_q  <= best_cost_d;
            best_upd_q   <= best_upd_d;
        end
    end

    assign tour.city_ready = city_ready;
    assign tour.cost_valid = cost_valid_q;
    assign tour.cost       = cost_q;
    assign tour.tour_err   = tour_err_q;
    assign tour.best_cost  = best_cost_q;
    assign tour.best_upd   = best_upd_q;

`ifdef TSP_BEST_TOUR_EN
    logic [CITY_W-1:0] tour_buf_q [N_CITY];
    logic [CITY_W-1:0] best_buf_q [N_CITY];

    // Position of an ACCUM beat is the count of cities already taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CITY; i++) begin
                tour_buf_q[i] <= '0;
                best_buf_q[i] <= '0;
            end
        end else begin
            if (accept && (state_q == IDLE)) begin
                tour_buf_q[0] <= tour.city_idx;
            end else if (accept && (int'(count_q) < N_CITY)) begin
                tour_buf_q[count_q[IDX_W-1:0]] <= tour.city_idx;
            end
            if (best_upd_d) begin
                for (int unsigned i = 0; i < N_CITY; i++) begin
                    best_buf_q[i] <= tour_buf_q[i];
                end
            end
        end
    end

    always_comb begin
        best_rd_city = '0;
        if (in_range(best_rd_idx)) begin
            best_rd_city = best_buf_q[best_rd_idx[IDX_W-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_tsp_tour_eval.sv
// Scoreboard bench for tsp_tour_eval: a 4-city evaluator plus a 9-bit-cost
// instance for saturation; monitors pop expected results on each strobe.
module tb_tsp_tour_eval;

    localparam int NC = 4;
    localparam int CW = 3;
    localparam int DW = 8;
    localparam int KW = 12;
    localparam int SW = 9;

    typedef struct {
        int    cost;
        int    err;
        int    upd;
        int    best;
        int    due;
        string name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          we1, we2, sat_en;
    logic [CW-1:0] wi, wj;
    logic [DW-1:0] wd;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    exp_t          q1[$];
    exp_t          q2[$];
    exp_t          e1, e2;
    int            stall_a, stall_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tsp_tour_eval_if #(.CITY_W(CW), .COST_W(KW)) t1 ();
    tsp_tour_eval_if #(.CITY_W(CW), .COST_W(SW)) t2 ();

    assign t2.city_valid = t1.city_valid & sat_en;
    assign t2.city_idx   = t1.city_idx;
    assign t2.city_last  = t1.city_last;

`ifdef TSP_BEST_TOUR_EN
    logic [CW-1:0] rd_idx, rd1, rd2;
`endif

    tsp_tour_eval #(.N_CITY(NC), .CITY_W(CW), .DIST_W(DW), .COST_W(KW)) dut (
        .clk(clk), .rst(rst), .dist_we(we1), .dist_wi(wi), .dist_wj(wj), .dist_wdata(wd),
`ifdef TSP_BEST_TOUR_EN
        .best_rd_idx(rd_idx), .best_rd_city(rd1),
`endif
        .tour(t1)
    );

    tsp_tour_eval #(.N_CITY(NC), .CITY_W(CW), .DIST_W(DW), .COST_W(SW)) dut_sat (
        .clk(clk), .rst(rst), .dist_we(we2), .dist_wi(wi), .dist_wj(wj), .dist_wdata(wd),
`ifdef TSP_BEST_TOUR_EN
        .best_rd_idx(rd_idx), .best_rd_city(rd2),
`endif
        .tour(t2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (t1.cost_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected strobe dut", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check({e1.name, " cost"}, int'(t1.cost), e1.cost);
                check({e1.name, " tour_err"}, int'(t1.tour_err), e1.err);
                check({e1.name, " best_upd"}, int'(t1.best_upd), e1.upd);
                check({e1.name, " best_cost"}, int'(t1.best_cost), e1.best);
                check({e1.name, " latency"}, cyc, e1.due);
            end
        end
    end

    always @(negedge clk) begin
        if (t2.cost_valid === 1'b1) begin
            if (q2.size() == 0) begin
                check("unexpected strobe dut_sat", 1, 0);
            end else begin
                e2 = q2.pop_front();
                check({e2.name, " sat cost"}, int'(t2.cost), e2.cost);
                check({e2.name, " sat tour_err"}, int'(t2.tour_err), e2.err);
                check({e2.name, " sat best_upd"}, int'(t2.best_upd), e2.upd);
                check({e2.name, " sat best_cost"}, int'(t2.best_cost), e2.best);
                check({e2.name, " sat latency"}, cyc, e2.due);
            end
        end
    end

    task automatic wr(input bit sat, input int i, input int j, input int d);
        we1 = !sat;
        we2 = sat;
        wi  = CW'(i);
        wj  = CW'(j);
        wd  = DW'(d);
        @(posedge clk);
        #1;
        we1 = 1'b0;
        we2 = 1'b0;
    endtask

    task automatic sym(input int i, input int j, input int d);
        wr(1'b0, i, j, d);
        wr(1'b0, j, i, d);
    endtask

    task automatic send_tour(input string name, input int c[8], input int n,
                             input int ec, input int ee, input int eu, input int eb,
                             input bit sat, input bit keep, output int stall0);
        int   stalls;
        bit   r;
        int   cy;
        exp_t e;
        stall0 = 0;
        r = 1'b0;
        cy = 0;
        for (int i = 0; i < n; i++) begin
            t1.city_valid = 1'b1;
            t1.city_idx   = CW'(c[i]);
            t1.city_last  = (i == n - 1);
            stalls = 0;
            forever begin
                @(negedge clk);
                r  = t1.city_ready;
                cy = cyc;
                @(posedge clk);
                if (r || stalls > 20) break;
                stalls++;
            end
            if (i == 0) stall0 = stalls;
            #1;
            if (!r) begin
                check({name, " accept timeout"}, 0, 1);
                t1.city_valid = 1'b0;
                return;
            end
        end
        e = '{ec, ee, eu, eb, cy + 3, name};
        q1.push_back(e);
        if (sat) begin
            e = '{511, 0, 0, 511, cy + 3, name};
            q2.push_back(e);
        end
        if (!keep) begin
            t1.city_valid = 1'b0;
            t1.city_last  = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q1.size() + q2.size()) != 0; k++) @(posedge clk);
        check("scoreboard drained", q1.size() + q2.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we1 = 1'b0; we2 = 1'b0; sat_en = 1'b0;
        wi = '0; wj = '0; wd = '0;
        t1.city_valid = 1'b0; t1.city_idx = '0; t1.city_last = 1'b0;
`ifdef TSP_BEST_TOUR_EN
        rd_idx = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset city_ready", int'(t1.city_ready), 1);
        check("reset cost_valid", int'(t1.cost_valid), 0);
        check("reset cost", int'(t1.cost), 0);
        check("reset tour_err", int'(t1.tour_err), 0);
        check("reset best_upd", int'(t1.best_upd), 0);
        check("reset best_cost", int'(t1.best_cost), 4095);
        check("reset sat best_cost", int'(t2.best_cost), 511);
        rst = 1'b0;
        @(posedge clk);
        #1;

        sym(0, 1, 1); sym(1, 2, 2); sym(2, 3, 3);
        sym(3, 0, 4); sym(0, 2, 5); sym(1, 3, 6);
        for (int i = 0; i < NC; i++)
            for (int j = 0; j < NC; j++) wr(1'b1, i, j, 255);

        send_tour("t0123", '{0,1,2,3,0,0,0,0}, 4, 10, 0, 1, 10, 1'b0, 1'b0, stall_a);
        drain();
        check("cost hold", int'(t1.cost), 10);
        check("strobe single cycle", int'(t1.cost_valid), 0);
`ifdef TSP_BEST_TOUR_EN
        for (int k = 0; k < NC; k++) begin
            rd_idx = CW'(k);
            #1;
            check("best_rd_city", int'(rd1), k);
        end
        rd_idx = 3'd5;
        #1;
        check("best_rd_city out of range", int'(rd1), 0);
        check("sat best_rd_city untouched", int'(rd2), 0);
`endif

        send_tour("t0213", '{0,2,1,3,0,0,0,0}, 4, 17, 0, 0, 10, 1'b0, 1'b0, stall_a);
        send_tour("t1230 tie", '{1,2,3,0,0,0,0,0}, 4, 10, 0, 0, 10, 1'b0, 1'b0, stall_a);
        send_tour("t0113 dup", '{0,1,1,3,0,0,0,0}, 4, 11, 1, 0, 10, 1'b0, 1'b0, stall_a);
        send_tour("t012 short", '{0,1,2,0,0,0,0,0}, 3, 8, 1, 0, 10, 1'b0, 1'b0, stall_a);
        send_tour("t0153 badidx", '{0,1,5,3,0,0,0,0}, 4, 5, 1, 0, 10, 1'b0, 1'b0, stall_a);
        drain();

        sat_en = 1'b1;
        send_tour("t0123 sat", '{0,1,2,3,0,0,0,0}, 4, 10, 0, 0, 10, 1'b1, 1'b0, stall_a);
        drain();
        sat_en = 1'b0;

        send_tour("bp A", '{0,2,1,3,0,0,0,0}, 4, 17, 0, 0, 10, 1'b0, 1'b1, stall_a);
        send_tour("bp B", '{0,1,3,2,0,0,0,0}, 4, 15, 0, 0, 10, 1'b0, 1'b0, stall_b);
        check("bp first stall", stall_a, 0);
        check("bp ready low cycles", stall_b, 2);
        drain();

        t1.city_valid = 1'b1; t1.city_idx = 3'd0; t1.city_last = 1'b0;
        @(posedge clk); #1;
        t1.city_idx = 3'd1;
        @(posedge clk); #1;
        t1.city_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midtour reset best_cost", int'(t1.best_cost), 4095);
        check("midtour reset city_ready", int'(t1.city_ready), 1);
        check("midtour reset cost", int'(t1.cost), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_tour("post-reset t0123", '{0,1,2,3,0,0,0,0}, 4, 0, 0, 1, 0, 1'b0, 1'b0, stall_a);
        drain();
`ifdef TSP_BEST_TOUR_EN
        for (int k = 0; k < NC; k++) begin
            rd_idx = CW'(k);
            #1;
            check("post-reset best_rd_city", int'(rd1), k);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
